// File: rtl/iomem_hakem.sv
// Round-robin arbiter sharing the external iomem bus between the L1B (instruction refill)
// and L1V (data refill/writeback) ports, with a watchdog that aborts unacknowledged transfers.
module iomem_hakem #(
    parameter logic [31:0] ADRES_TABANI = 32'h4000_0000,
    parameter int unsigned ZAMAN_ASIMI  = 1024,
    parameter logic [31:0] HATA_VERI    = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        l1b_iomem_valid,
    input  logic [16:0] l1b_iomem_addr,
    output logic        l1b_iomem_ready,
    output logic [31:0] l1b_iomem_rdata,

    input  logic        l1v_iomem_valid,
    input  logic [3:0]  l1v_iomem_wstrb,
    input  logic [16:0] l1v_iomem_addr,
    input  logic [31:0] l1v_iomem_wdata,
    output logic        l1v_iomem_ready,
    output logic [31:0] l1v_iomem_rdata,

    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,

    output logic        hata_o
);

    typedef enum logic [1:0] {
        BOS,
        L1B_AKTIF,
        L1V_AKTIF
    } durum_t;

    localparam logic [15:0] SON_SAYAC = 16'(ZAMAN_ASIMI - 1);

    durum_t      durum_q;
    logic        son_kazanan_q;  // 1: L1V won the last grant
    logic [15:0] sayac_q;
    logic        iomem_valid_q;
    logic [3:0]  iomem_wstrb_q;
    logic [31:0] iomem_addr_q;
    logic [31:0] iomem_wdata_q;

    logic        aktif;
    logic        zaman_doldu;
    logic        bitis;
    logic        l1b_sec;
    logic        l1v_sec;
    logic [31:0] cevap_veri;

    assign aktif       = (durum_q != BOS);
    assign zaman_doldu = (sayac_q == SON_SAYAC);
    assign bitis       = aktif && (iomem_ready || zaman_doldu);

    // On a tie the requester that did not win last time is granted.
    assign l1b_sec = l1b_iomem_valid && (!l1v_iomem_valid || son_kazanan_q);
    assign l1v_sec = l1v_iomem_valid && !l1b_sec;

    // NOTE: every register, bus payload included, is cleared by the async reset so the
    // pins fall the moment rstn_i drops; all state updates use non-blocking assignments.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q       <= BOS;
            son_kazanan_q <= 1'b1;
            sayac_q       <= '0;
            iomem_valid_q <= 1'b0;
            iomem_wstrb_q <= '0;
            iomem_addr_q  <= '0;
            iomem_wdata_q <= '0;
        end else begin
            case (durum_q)
                BOS: begin
                    if (l1b_sec) begin
                        durum_q       <= L1B_AKTIF;
                        son_kazanan_q <= 1'b0;
                        iomem_valid_q <= 1'b1;
                        iomem_addr_q  <= {ADRES_TABANI[31:19], l1b_iomem_addr, 2'b00};
                        iomem_wstrb_q <= 4'b0000;
                        iomem_wdata_q <= '0;
                    end else if (l1v_sec) begin
                        durum_q       <= L1V_AKTIF;
                        son_kazanan_q <= 1'b1;
                        iomem_valid_q <= 1'b1;
                        iomem_addr_q  <= {ADRES_TABANI[31:19], l1v_iomem_addr, 2'b00};
                        iomem_wstrb_q <= l1v_iomem_wstrb;
                        iomem_wdata_q <= l1v_iomem_wdata;
                    end
                end
                default: begin
                    if (bitis) begin
                        durum_q       <= BOS;
                        iomem_valid_q <= 1'b0;
                        sayac_q       <= '0;
                    end else begin
                        sayac_q <= sayac_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // A real acknowledge wins over a simultaneous timeout.
    assign cevap_veri = iomem_ready ? iomem_rdata : HATA_VERI;

    assign l1b_iomem_ready = (durum_q == L1B_AKTIF) && bitis;
    assign l1v_iomem_ready = (durum_q == L1V_AKTIF) && bitis;
    assign l1b_iomem_rdata = l1b_iomem_ready ? cevap_veri : '0;
    assign l1v_iomem_rdata = l1v_iomem_ready ? cevap_veri : '0;
    assign hata_o          = aktif && zaman_doldu && !iomem_ready;

    assign iomem_valid = iomem_valid_q;
    assign iomem_wstrb = iomem_wstrb_q;
    assign iomem_addr  = iomem_addr_q;
    assign iomem_wdata = iomem_wdata_q;

endmodule

// File: tb/tb_iomem_hakem.sv
// Directed bench for iomem_hakem: table of transactions plus a mid-transaction reset sequence.
module tb_iomem_hakem;

    localparam int ZA = 8;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        l1b_iomem_valid;
    logic [16:0] l1b_iomem_addr;
    logic        l1b_iomem_ready;
    logic [31:0] l1b_iomem_rdata;
    logic        l1v_iomem_valid;
    logic [3:0]  l1v_iomem_wstrb;
    logic [16:0] l1v_iomem_addr;
    logic [31:0] l1v_iomem_wdata;
    logic        l1v_iomem_ready;
    logic [31:0] l1v_iomem_rdata;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        hata_o;

    int n_check = 0;
    int n_err   = 0;

    always #5 clk_i = ~clk_i;

    iomem_hakem #(.ZAMAN_ASIMI(ZA)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .l1b_iomem_valid (l1b_iomem_valid),
        .l1b_iomem_addr  (l1b_iomem_addr),
        .l1b_iomem_ready (l1b_iomem_ready),
        .l1b_iomem_rdata (l1b_iomem_rdata),
        .l1v_iomem_valid (l1v_iomem_valid),
        .l1v_iomem_wstrb (l1v_iomem_wstrb),
        .l1v_iomem_addr  (l1v_iomem_addr),
        .l1v_iomem_wdata (l1v_iomem_wdata),
        .l1v_iomem_ready (l1v_iomem_ready),
        .l1v_iomem_rdata (l1v_iomem_rdata),
        .iomem_valid     (iomem_valid),
        .iomem_ready     (iomem_ready),
        .iomem_wstrb     (iomem_wstrb),
        .iomem_addr      (iomem_addr),
        .iomem_wdata     (iomem_wdata),
        .iomem_rdata     (iomem_rdata),
        .hata_o          (hata_o)
    );

    typedef struct {
        logic        b_v;
        logic [16:0] b_addr;
        logic        v_v;
        logic [3:0]  v_wstrb;
        logic [16:0] v_addr;
        logic [31:0] v_wdata;
        int          bekle;      // active cycle of iomem_ready; 0 = never
        logic [31:0] mem_rdata;
        logic        kazanan;    // 0: L1B, 1: L1V
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_hata;
    } vektor_t;

    vektor_t tablo [11];

    task automatic check(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        n_check++;
        if (gercek !== beklenen) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", ad, gercek, beklenen, $time);
        end
    endtask

    task automatic run_vec(input vektor_t v);
        int son_dongu;
        son_dongu = (v.bekle == 0) ? ZA : v.bekle;
        @(negedge clk_i);
        l1b_iomem_valid = v.b_v;
        l1b_iomem_addr  = v.b_addr;
        l1v_iomem_valid = v.v_v;
        l1v_iomem_wstrb = v.v_wstrb;
        l1v_iomem_addr  = v.v_addr;
        l1v_iomem_wdata = v.v_wdata;
        iomem_ready     = 1'b0;
        iomem_rdata     = v.mem_rdata;
        @(posedge clk_i); #1;
        check("grant_valid", iomem_valid, 1);
        check("grant_addr", iomem_addr, v.exp_addr);
        check("grant_wstrb", iomem_wstrb, v.exp_wstrb);
        check("grant_wdata", iomem_wdata, v.exp_wdata);
        for (int c = 1; c < son_dongu; c++) begin
            @(negedge clk_i); #1;
            check("stall_ready", {l1b_iomem_ready, l1v_iomem_ready, hata_o}, 3'b000);
            check("stall_bus", {iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata},
                  {1'b1, v.exp_wstrb, v.exp_addr, v.exp_wdata});
            @(posedge clk_i);
        end
        @(negedge clk_i);
        iomem_ready = (v.bekle != 0);
        #1;
        if (v.kazanan) begin
            check("l1v_ready", l1v_iomem_ready, 1);
            check("l1v_rdata", l1v_iomem_rdata, v.exp_rdata);
            check("l1b_idle", {l1b_iomem_ready, l1b_iomem_rdata}, 0);
            l1v_iomem_valid = 1'b0;
        end else begin
            check("l1b_ready", l1b_iomem_ready, 1);
            check("l1b_rdata", l1b_iomem_rdata, v.exp_rdata);
            check("l1v_idle", {l1v_iomem_ready, l1v_iomem_rdata}, 0);
            l1b_iomem_valid = 1'b0;
        end
        check("hata", hata_o, v.exp_hata);
        @(posedge clk_i); #1;
        check("done_valid", iomem_valid, 0);
        check("done_quiet", {l1b_iomem_ready, l1v_iomem_ready, hata_o}, 0);
        iomem_ready = 1'b0;
    endtask

    initial begin
        tablo[0]  = '{1'b1, 17'h00001, 1'b1, 4'hF, 17'h00002, 32'h1111_1111, 1, 32'h0000_00A0,
                      1'b0, 32'h4000_0004, 4'h0, 32'h0, 32'h0000_00A0, 1'b0};
        tablo[1]  = '{1'b1, 17'h00003, 1'b1, 4'hF, 17'h00002, 32'h1111_1111, 1, 32'h0000_00A1,
                      1'b1, 32'h4000_0008, 4'hF, 32'h1111_1111, 32'h0000_00A1, 1'b0};
        tablo[2]  = '{1'b1, 17'h00003, 1'b1, 4'h0, 17'h00004, 32'h0, 1, 32'h0000_00A2,
                      1'b0, 32'h4000_000C, 4'h0, 32'h0, 32'h0000_00A2, 1'b0};
        tablo[3]  = '{1'b1, 17'h08000, 1'b1, 4'h0, 17'h00004, 32'h0, 1, 32'h0000_00A3,
                      1'b1, 32'h4000_0010, 4'h0, 32'h0, 32'h0000_00A3, 1'b0};
        tablo[4]  = '{1'b1, 17'h08000, 1'b1, 4'h3, 17'h10000, 32'hCAFE_0001, 1, 32'h0000_00A4,
                      1'b0, 32'h4002_0000, 4'h0, 32'h0, 32'h0000_00A4, 1'b0};
        tablo[5]  = '{1'b1, 17'h00010, 1'b1, 4'h3, 17'h10000, 32'hCAFE_0001, 1, 32'h0000_00A5,
                      1'b1, 32'h4004_0000, 4'h3, 32'hCAFE_0001, 32'h0000_00A5, 1'b0};
        tablo[6]  = '{1'b1, 17'h00010, 1'b0, 4'h0, 17'h00000, 32'h0, 3, 32'h1234_5678,
                      1'b0, 32'h4000_0040, 4'h0, 32'h0, 32'h1234_5678, 1'b0};
        tablo[7]  = '{1'b0, 17'h00000, 1'b1, 4'h5, 17'h1FFFF, 32'hA5A5_5A5A, 4, 32'h7777_0000,
                      1'b1, 32'h4007_FFFC, 4'h5, 32'hA5A5_5A5A, 32'h7777_0000, 1'b0};
        tablo[8]  = '{1'b1, 17'h00020, 1'b0, 4'h0, 17'h00000, 32'h0, 2, 32'h5555_AAAA,
                      1'b0, 32'h4000_0080, 4'h0, 32'h0, 32'h5555_AAAA, 1'b0};
        tablo[9]  = '{1'b1, 17'h00021, 1'b1, 4'h0, 17'h00100, 32'h0, 0, 32'h9999_9999,
                      1'b1, 32'h4000_0400, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1};
        tablo[10] = '{1'b1, 17'h00021, 1'b0, 4'h0, 17'h00000, 32'h0, 8, 32'h0BAD_F00D,
                      1'b0, 32'h4000_0084, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0};

        rstn_i          = 1'b0;
        l1b_iomem_valid = 1'b0;
        l1b_iomem_addr  = '0;
        l1v_iomem_valid = 1'b0;
        l1v_iomem_wstrb = '0;
        l1v_iomem_addr  = '0;
        l1v_iomem_wdata = '0;
        iomem_ready     = 1'b0;
        iomem_rdata     = '0;
        #1;
        check("reset_bus", {iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata}, 0);
        check("reset_req", {l1b_iomem_ready, l1v_iomem_ready, hata_o}, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tablo[i]);

        // Reset pulse in the middle of an L1V write.
        @(negedge clk_i);
        l1v_iomem_valid = 1'b1;
        l1v_iomem_wstrb = 4'hF;
        l1v_iomem_addr  = 17'h00050;
        l1v_iomem_wdata = 32'h0000_1234;
        @(posedge clk_i); #1;
        check("rst_seq_grant", {iomem_valid, iomem_addr}, {1'b1, 32'h4000_0140});
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i      = 1'b0;
        iomem_ready = 1'b1;
        #1;
        check("rst_async_bus", {iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata}, 0);
        check("rst_no_ready", {l1b_iomem_ready, l1v_iomem_ready, hata_o, l1v_iomem_rdata}, 0);
        @(negedge clk_i);
        rstn_i          = 1'b1;
        iomem_ready     = 1'b0;
        iomem_rdata     = 32'h0000_0C0C;
        l1b_iomem_valid = 1'b1;
        l1b_iomem_addr  = 17'h00007;
        @(posedge clk_i); #1;
        check("rst_tie_l1b", {iomem_valid, iomem_addr, iomem_wstrb}, {1'b1, 32'h4000_001C, 4'h0});
        @(negedge clk_i);
        iomem_ready = 1'b1;
        #1;
        check("rst_l1b_done", {l1b_iomem_ready, l1b_iomem_rdata}, {1'b1, 32'h0000_0C0C});
        check("rst_l1v_wait", l1v_iomem_ready, 0);
        l1b_iomem_valid = 1'b0;
        l1v_iomem_valid = 1'b0;
        @(posedge clk_i); #1;
        iomem_ready = 1'b0;
        check("rst_seq_idle", iomem_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_check, n_err);
        $finish;
    end

endmodule
